// File: rtl/maze_dir_picker.sv
// rtl/maze_dir_picker.sv - picks one open maze direction uniformly via LFSR rejection sampling
module maze_dir_picker #(
    parameter int RAND_BITS = 8,
    parameter int MAX_TRIES = 15
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic                 i_Req,
    input  logic [3:0]           i_Mask,
    input  logic [RAND_BITS-1:0] i_Rand_Data,
    output logic                 o_Rand_Enable,
    output logic                 o_Busy,
    output logic                 o_Valid,
    output logic [1:0]           o_Dir,
    output logic                 o_None,
    output logic                 o_Fallback
);

    localparam int TW = $clog2(MAX_TRIES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_State;
    logic [3:0]      r_Mask;
    logic [TW-1:0]   r_Tries;
    logic [1:0]      r_Dir;
    logic            r_None;
    logic            r_Fallback;

    logic [1:0]      w_Cand;
    logic [TW-1:0]   w_Tries_Next;
    logic [2:0]      w_Mask_Cnt;
    logic [1:0]      w_Req_Low;
    logic [1:0]      w_Latched_Low;
    logic            w_unused_rand;

    function automatic logic [1:0] low_idx(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        for (int b = 3; b >= 0; b--) begin
            if (m[b]) idx = 2'(b);
        end
        return idx;
    endfunction

    assign w_Cand        = i_Rand_Data[1:0];
    assign w_unused_rand = &{1'b0, i_Rand_Data};
    assign w_Tries_Next  = r_Tries + TW'(1);
    assign w_Mask_Cnt    = {2'b00, i_Mask[0]} + {2'b00, i_Mask[1]}
                         + {2'b00, i_Mask[2]} + {2'b00, i_Mask[3]};
    assign w_Req_Low     = low_idx(i_Mask);
    assign w_Latched_Low = low_idx(r_Mask);

    // Handshake strobes are decoded straight from the state register so reset clears them at once.
    assign o_Rand_Enable = (r_State == S_DRAW);
    assign o_Busy        = (r_State != S_IDLE);
    assign o_Valid       = (r_State == S_DONE);
    assign o_Dir         = r_Dir;
    assign o_None        = r_None;
    assign o_Fallback    = r_Fallback;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State    <= S_IDLE;
            r_Mask     <= 4'd0;
            r_Tries    <= '0;
            r_Dir      <= 2'd0;
            r_None     <= 1'b0;
            r_Fallback <= 1'b0;
        end else begin
            case (r_State)
                S_IDLE: begin
                    if (i_Req) begin
                        r_Mask     <= i_Mask;
                        r_Tries    <= '0;
                        r_None     <= 1'b0;
                        r_Fallback <= 1'b0;
                        if (w_Mask_Cnt == 3'd0) begin
                            r_None  <= 1'b1;
                            r_Dir   <= 2'd0;
                            r_State <= S_DONE;
                        end else if (w_Mask_Cnt == 3'd1) begin
                            r_Dir   <= w_Req_Low;
                            r_State <= S_DONE;
                        end else begin
                            r_State <= S_DRAW;
                        end
                    end
                end
                S_DRAW: begin
                    if (r_Mask[w_Cand]) begin
                        r_Dir   <= w_Cand;
                        r_State <= S_DONE;
                    end else begin
                        r_Tries <= w_Tries_Next;
                        // Bound the walk's worst-case latency when the random source misbehaves.
                        if (w_Tries_Next == TW'(MAX_TRIES)) begin
                            r_Dir      <= w_Latched_Low;
                            r_Fallback <= 1'b1;
                            r_State    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_State <= S_IDLE;
                end
                default: begin
                    r_State <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maze_dir_picker.sv
// tb/tb_maze_dir_picker.sv - directed vector bench for maze_dir_picker
module tb_maze_dir_picker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_Req;
    logic [3:0] i_Mask;
    logic [7:0] drive_rand;
    logic       use_lfsr;
    logic [7:0] lfsr;
    logic [7:0] rand_data;
    logic       o_Rand_Enable, o_Busy, o_Valid, o_None, o_Fallback;
    logic [1:0] o_Dir;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rand_data = use_lfsr ? lfsr : drive_rand;

    // Maximal-length 8-bit LFSR, x^8+x^6+x^5+x^4+1, advanced only on the picker's enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= 8'h01;
        else if (o_Rand_Enable) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    maze_dir_picker #(.RAND_BITS(8), .MAX_TRIES(15)) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .i_Req        (i_Req),
        .i_Mask       (i_Mask),
        .i_Rand_Data  (rand_data),
        .o_Rand_Enable(o_Rand_Enable),
        .o_Busy       (o_Busy),
        .o_Valid      (o_Valid),
        .o_Dir        (o_Dir),
        .o_None       (o_None),
        .o_Fallback   (o_Fallback)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one pick; r0/r1 feed the first two draw edges, r2 every later one.
    task automatic run_pick(input logic [3:0] mask, input logic [7:0] r0, input logic [7:0] r1,
                            input logic [7:0] r2, output int lat, output int en_cnt);
        int rsel;
        i_Mask = mask;
        i_Req = 1'b1;
        drive_rand = r0;
        rsel = 0;
        tick();
        i_Req = 1'b0;
        i_Mask = ~mask;
        lat = 1;
        en_cnt = 0;
        while (!o_Valid && lat < 40) begin
            if (o_Rand_Enable) en_cnt++;
            tick();
            lat++;
            rsel++;
            drive_rand = (rsel == 1) ? r1 : r2;
        end
    endtask

    typedef struct {
        logic [3:0] mask;
        logic [7:0] r;
        logic [1:0] dir;
        logic       none;
        logic       fb;
        int         lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int lat, en;
        int valids, consec, bad, picks, cyc;
        int hist[4];
        logic prev_valid;

        vecs[0] = '{4'b0100, 8'h00, 2'd2, 1'b0, 1'b0, 1};
        vecs[1] = '{4'b0000, 8'h00, 2'd0, 1'b1, 1'b0, 1};
        vecs[2] = '{4'b1000, 8'h55, 2'd3, 1'b0, 1'b0, 1};
        vecs[3] = '{4'b1010, 8'h03, 2'd3, 1'b0, 1'b0, 2};
        vecs[4] = '{4'b1111, 8'hFE, 2'd2, 1'b0, 1'b0, 2};
        vecs[5] = '{4'b0011, 8'h01, 2'd1, 1'b0, 1'b0, 2};
        vecs[6] = '{4'b0110, 8'h00, 2'd1, 1'b0, 1'b1, 16};
        vecs[7] = '{4'b1001, 8'h02, 2'd0, 1'b0, 1'b1, 16};
        vecs[8] = '{4'b1100, 8'h0F, 2'd3, 1'b0, 1'b0, 2};

        rst_n = 1'b0;
        i_Req = 1'b0;
        i_Mask = 4'd0;
        drive_rand = 8'd0;
        use_lfsr = 1'b0;
        #12;
        chk("rst_busy", o_Busy, 0);
        chk("rst_valid", o_Valid, 0);
        chk("rst_en", o_Rand_Enable, 0);
        chk("rst_dir", o_Dir, 0);
        chk("rst_none", o_None, 0);
        chk("rst_fb", o_Fallback, 0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            run_pick(vecs[i].mask, vecs[i].r, vecs[i].r, vecs[i].r, lat, en);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_en", i), en, vecs[i].lat - 1);
            chk($sformatf("v%0d_dir", i), o_Dir, vecs[i].dir);
            chk($sformatf("v%0d_none", i), o_None, vecs[i].none);
            chk($sformatf("v%0d_fb", i), o_Fallback, vecs[i].fb);
            tick();
            chk($sformatf("v%0d_valid_drop", i), o_Valid, 0);
            chk($sformatf("v%0d_dir_hold", i), o_Dir, vecs[i].dir);
            chk($sformatf("v%0d_idle", i), o_Busy, 0);
        end

        run_pick(4'b1010, 8'h00, 8'h02, 8'h03, lat, en);
        chk("seq023_lat", lat, 4);
        chk("seq023_en", en, 3);
        chk("seq023_dir", o_Dir, 3);
        chk("seq023_fb", o_Fallback, 0);
        tick();

        i_Mask = 4'b0010;
        i_Req = 1'b1;
        valids = 0;
        consec = 0;
        prev_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (o_Valid) begin
                valids++;
                if (o_Dir != 2'd1) consec++;
            end
            if (prev_valid && o_Valid) consec++;
            prev_valid = o_Valid;
        end
        i_Req = 1'b0;
        chk("thru_valids", valids, 4);
        chk("thru_bad", consec, 0);
        tick();
        tick();

        i_Mask = 4'b0110;
        drive_rand = 8'h00;
        i_Req = 1'b1;
        tick();
        i_Req = 1'b0;
        tick();
        tick();
        chk("mid_draw_en", o_Rand_Enable, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", o_Busy, 0);
        chk("arst_en", o_Rand_Enable, 0);
        chk("arst_valid", o_Valid, 0);
        chk("arst_dir", o_Dir, 0);
        tick();
        #3;
        rst_n = 1'b1;
        valids = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (o_Valid || o_Busy) valids++;
        end
        chk("post_rst_idle", valids, 0);

        use_lfsr = 1'b1;
        i_Mask = 4'hF;
        i_Req = 1'b1;
        picks = 0;
        bad = 0;
        consec = 0;
        cyc = 0;
        prev_valid = 1'b0;
        for (int d = 0; d < 4; d++) hist[d] = 0;
        while (picks < 4000 && cyc < 20000) begin
            tick();
            cyc++;
            if (o_Valid) begin
                hist[o_Dir]++;
                picks++;
                if (o_None || o_Fallback) bad++;
            end
            if (prev_valid && o_Valid) consec++;
            prev_valid = o_Valid;
            i_Mask = o_Busy ? 4'($urandom_range(0, 15)) : 4'hF;
        end
        i_Req = 1'b0;
        chk("lfsr_picks", picks, 4000);
        chk("lfsr_consec_valid", consec, 0);
        chk("lfsr_none_or_fb", bad, 0);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("hist_dir%0d=%0d_in_900_1100", d, hist[d]),
                int'(hist[d] >= 900 && hist[d] <= 1100), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
